// File: rtl/alu_cmd_issuer_if.sv
// Command/response bus between a command source and alu_cmd_issuer.
// The master issues commands and accepts responses; the slave is the issuer.
interface alu_cmd_issuer_if #(
  parameter int n = 31
) ();
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_load;
  logic [2:0] cmd_op;
  logic [1:0] cmd_rd;
  logic [1:0] cmd_ra;
  logic [1:0] cmd_rb;
  logic       cmd_imm_sel;
  logic [n:0] cmd_imm;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [n:0] rsp_data;
  logic       rsp_z;
  logic       rsp_c;
  logic       rsp_err;

  modport master (
    output cmd_valid, cmd_load, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_imm_sel, cmd_imm,
    input  cmd_ready,
    input  rsp_valid, rsp_data, rsp_z, rsp_c, rsp_err,
    output rsp_ready
  );

  modport slave (
    input  cmd_valid, cmd_load, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_imm_sel, cmd_imm,
    output cmd_ready,
    output rsp_valid, rsp_data, rsp_z, rsp_c, rsp_err,
    input  rsp_ready
  );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Issues register-file commands to an external combinational ALU and returns responses.
// Optional macro ALU_DIV0_TRAP_EN traps opcode 011 with a zero B operand.
module alu_cmd_issuer #(
  parameter int n = 31
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_cmd_issuer_if.slave      bus,
  output logic [n:0]           alu_a,
  output logic [n:0]           alu_b,
  output logic [2:0]           alu_op,
  input  logic [n:0]           alu_out,
  input  logic                 alu_z,
  input  logic                 alu_c,
  input  logic [1:0]           dbg_addr,
  output logic [n:0]           dbg_data
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e     r_state;
  state_e     w_state_next;
  logic [n:0] r_rf [4];
  logic [n:0] r_alu_a;
  logic [n:0] r_alu_b;
  logic [2:0] r_alu_op;
  logic [1:0] r_rd;
  logic [n:0] r_rsp_data;
  logic       r_rsp_z;
  logic       r_rsp_c;
  logic       r_rsp_err;
  logic       w_accept;
  logic       w_div0;

  assign w_accept = (r_state == StIdle) && bus.cmd_valid;

`ifdef ALU_DIV0_TRAP_EN
  assign w_div0 = (r_alu_op == 3'b011) && (r_alu_b == '0);
`else
  assign w_div0 = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (bus.cmd_valid) w_state_next = bus.cmd_load ? StResp : StExec;
      StExec: w_state_next = StResp;
      StResp: if (bus.rsp_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      for (int i = 0; i < 4; i++) r_rf[i] <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_op   <= 3'b000;
      r_rd       <= 2'd0;
      r_rsp_data <= '0;
      r_rsp_z    <= 1'b0;
      r_rsp_c    <= 1'b0;
      r_rsp_err  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        if (bus.cmd_load) begin
          r_rf[bus.cmd_rd] <= bus.cmd_imm;
          r_rsp_data       <= bus.cmd_imm;
          r_rsp_z          <= (bus.cmd_imm == '0);
          r_rsp_c          <= 1'b0;
          r_rsp_err        <= 1'b0;
        end else begin
          // Operands are read before any write, so aliased rd/ra/rb see old values.
          r_alu_a  <= r_rf[bus.cmd_ra];
          r_alu_b  <= bus.cmd_imm_sel ? bus.cmd_imm : r_rf[bus.cmd_rb];
          r_alu_op <= bus.cmd_op;
          r_rd     <= bus.cmd_rd;
        end
      end
      if (r_state == StExec) begin
        if (w_div0) begin
          r_rsp_data <= '0;
          r_rsp_z    <= 1'b1;
          r_rsp_c    <= 1'b0;
          r_rsp_err  <= 1'b1;
        end else begin
          r_rf[r_rd] <= alu_out;
          r_rsp_data <= alu_out;
          r_rsp_z    <= alu_z;
          r_rsp_c    <= alu_c;
          r_rsp_err  <= 1'b0;
        end
      end
    end
  end

  assign bus.cmd_ready = (r_state == StIdle);
  assign bus.rsp_valid = (r_state == StResp);
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_z     = r_rsp_z;
  assign bus.rsp_c     = r_rsp_c;
  assign bus.rsp_err   = r_rsp_err;
  assign alu_a         = r_alu_a;
  assign alu_b         = r_alu_b;
  assign alu_op        = r_alu_op;
  assign dbg_data      = r_rf[dbg_addr];

endmodule
